door_ctrl: RTL and testbench
============================

# door_ctrl

Elevator car door controller with a synchronous state machine. It opens the door only when the car is stationary and exactly one floor sensor is asserted. It holds the door open for a minimum dwell, then closes it, and forces closure whenever the car starts moving. It sits between the floor-sensor/motion logic and the door actuator, and reports `busy` back to motion control.

## Interface
- OPEN_DELAY, 2: cycles spent in OPENING before the door reports open (≥1).
- HOLD_CYCLES, 4: minimum cycles in OPEN before a normal close (≥1).
- CLOSE_DELAY, 2: cycles spent in CLOSING before the door reports closed (≥1).
- clk  in  1  single system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- moving  in  1  car in motion.
- f1  in  1  floor 1 sensor.
- f2  in  1  floor 2 sensor.
- f3  in  1  floor 3 sensor.
- door  out  1  1 = door fully open, 0 = closed or in transit.
- busy  out  1  1 whenever state ≠ CLOSED; motion control must not start while high.
- floor  out  2  floor code latched when leaving CLOSED: 0 = none, 1..3 = f1..f3.
- fault  out  1  registered error flag, valid for one cycle per offending sample.

## Operation
- `sensors_ok` = exactly one of f1/f2/f3 high.
- `at_floor` = !moving & sensors_ok.
- States (package enum): CLOSED, OPENING, OPEN, CLOSING. One shared down-counter.
- Reset: state = CLOSED, counter = 0, door = 0, busy = 0, floor = 0, fault = 0.
- CLOSED:
  - If `at_floor`, go to OPENING, load counter = OPEN_DELAY−1, latch `floor`.
  - Otherwise stay.
- OPENING:
  - If moving or !at_floor, go to CLOSING and load CLOSE_DELAY−1.
  - Else if counter == 0, go to OPEN and load HOLD_CYCLES−1.
  - Else decrement the counter.
- OPEN:
  - If moving, go to CLOSING immediately; this overrides the hold.
  - Else if counter ≠ 0, decrement the counter.
  - Else if !at_floor, go to CLOSING.
  - Else remain OPEN; the door stays open while the car remains parked at a valid floor.
- CLOSING:
  - If at_floor and !moving, reopen: go to OPENING with OPEN_DELAY−1.
  - Else if counter == 0, go to CLOSED and clear `floor` to 0.
  - Else decrement the counter.
- Outputs are registered: door = (state == OPEN), busy = (state ≠ CLOSED).
- fault is registered and set for a sample when either condition holds:
  - more than one floor sensor is high, or
  - moving = 1 while state ≠ CLOSED.
- No sensor or moving combination opens the door while moving = 1.
- All-sensors-low is not a fault; the door simply stays closed.

## Timing
- Inputs are sampled on the rising edge, with no input synchronizers; inputs must already be synchronous to `clk`.
- Open latency: when the edge sampling `at_floor` = 1 in CLOSED is edge 0, door rises after edge OPEN_DELAY. That is 2 cycles with the defaults.
- Minimum door-high time: HOLD_CYCLES cycles, unless a moving override occurs.
- Close latency:
  - door falls on the first edge after the close condition is sampled;
  - busy falls CLOSE_DELAY cycles later.
- Moving override: door = 0 one edge after moving is sampled high; fault is high in that same cycle.
- Reset has priority over all transitions. Reset asserted mid-open drives door = 0 and busy = 0 on the next edge.
- Simultaneous events: moving beats at_floor. A reopen request in CLOSING beats counter expiry.

## Structure
- Package `door_pkg`: state enum `door_state_t` (CLOSED, OPENING, OPEN, CLOSING) and floor code constants FLOOR_NONE/1/2/3.
- Sub-module `door_timer`: loadable down-counter, width = $clog2(max(OPEN_DELAY, HOLD_CYCLES, CLOSE_DELAY)+1), with load/value/decrement/zero flag.
- The top level holds the FSM, sensor decode and output registers.

## Test plan
- Reset, then moving = 0, f2 = 1 held → door = 1 two cycles after sampling, floor = 2, busy = 1, fault = 0.
- All 16 combinations of {moving, f1, f2, f3}, each held 10 cycles → door = 1 only for moving = 0 with exactly one f high; fault = 1 for multiple f high.
- Door OPEN, f1 drops after 1 cycle → door stays 1 until 4 hold cycles elapse, then 0; busy falls 2 cycles later; floor = 0.
- Door OPEN, moving = 1 → door = 0 and fault = 1 on the next edge, then CLOSED after 2 cycles.
- In CLOSING, f3 re-asserts with moving = 0 → OPENING, door = 1 two cycles later, floor = 3.
- rst pulsed while door = 1 → all outputs 0 on the next edge.

Source files
------------

// File: rtl/door_pkg.sv
// door_pkg: shared definitions for the elevator car door controller.
//   door_state_t : FSM state encoding (CLOSED, OPENING, OPEN, CLOSING)
//   FLOOR_*      : floor codes reported on door_ctrl.floor
//   max3         : helper used to size the shared dwell counter
package door_pkg;

    typedef enum logic [1:0] {
        CLOSED  = 2'd0,
        OPENING = 2'd1,
        OPEN    = 2'd2,
        CLOSING = 2'd3
    } door_state_t;

    localparam logic [1:0] FLOOR_NONE = 2'd0;
    localparam logic [1:0] FLOOR_1    = 2'd1;
    localparam logic [1:0] FLOOR_2    = 2'd2;
    localparam logic [1:0] FLOOR_3    = 2'd3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/door_timer.sv
// door_timer: loadable down-counter shared by all timed door states.
//   clk      : system clock
//   rst      : synchronous active-high reset, clears the count
//   load     : load load_val (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one; holds at zero
//   value    : current count
//   zero     : count == 0
module door_timer
    import door_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign value = cnt;
    assign zero  = (cnt == '0);

endmodule

// File: rtl/door_ctrl.sv
// door_ctrl: elevator car door controller.
//   clk    : system clock, all state updates on the rising edge
//   rst    : synchronous active-high reset
//   moving : car in motion
//   f1..f3 : floor sensors
//   door   : 1 = door fully open
//   busy   : 1 whenever the door is not fully closed and idle
//   floor  : floor code latched when the door starts opening, 0 once closed
//   fault  : one-cycle flag per sample with several sensors high, or
//            with the car moving while the door is not closed
module door_ctrl
    import door_pkg::*;
#(
    parameter int OPEN_DELAY  = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int CLOSE_DELAY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       moving,
    input  logic       f1,
    input  logic       f2,
    input  logic       f3,
    output logic       door,
    output logic       busy,
    output logic [1:0] floor,
    output logic       fault
);

    localparam int CNT_W = $clog2(max3(OPEN_DELAY, HOLD_CYCLES, CLOSE_DELAY) + 1);

    localparam logic [CNT_W-1:0] OPEN_LOAD  = CNT_W'(OPEN_DELAY - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLOSE_LOAD = CNT_W'(CLOSE_DELAY - 1);

    door_state_t      state, state_d;
    logic             tmr_load, tmr_dec, tmr_zero;
    logic [CNT_W-1:0] tmr_val, tmr_value;
    logic [1:0]       floor_d, sensor_code;
    logic             door_d, busy_d, fault_d;
    logic             multi, sensors_ok, at_floor;

    // Sensor decode
    assign multi       = (f1 & f2) | (f1 & f3) | (f2 & f3);
    assign sensors_ok  = (f1 ^ f2 ^ f3) & ~multi;
    assign at_floor    = ~moving & sensors_ok;
    assign sensor_code = f1 ? FLOOR_1 : (f2 ? FLOOR_2 : (f3 ? FLOOR_3 : FLOOR_NONE));

    door_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .value    (tmr_value),
        .zero     (tmr_zero)
    );

    // State and output registers. Outputs are registered from the next
    // state so door/busy track the state register without an extra cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLOSED;
            door  <= 1'b0;
            busy  <= 1'b0;
            floor <= FLOOR_NONE;
            fault <= 1'b0;
        end else begin
            state <= state_d;
            door  <= door_d;
            busy  <= busy_d;
            floor <= floor_d;
            fault <= fault_d;
        end
    end

    // Next-state, timer control and floor latch
    always_comb begin
        state_d  = state;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;
        floor_d  = floor;
        unique case (state)
            CLOSED: begin
                if (at_floor) begin
                    state_d  = OPENING;
                    tmr_load = 1'b1;
                    tmr_val  = OPEN_LOAD;
                    floor_d  = sensor_code;
                end
            end
            OPENING: begin
                if (!at_floor) begin
                    state_d  = CLOSING;
                    tmr_load = 1'b1;
                    tmr_val  = CLOSE_LOAD;
                end else if (tmr_zero) begin
                    state_d  = OPEN;
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LOAD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            OPEN: begin
                // Motion overrides the minimum hold.
                if (moving) begin
                    state_d  = CLOSING;
                    tmr_load = 1'b1;
                    tmr_val  = CLOSE_LOAD;
                end else if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                end else if (!at_floor) begin
                    state_d  = CLOSING;
                    tmr_load = 1'b1;
                    tmr_val  = CLOSE_LOAD;
                end
            end
            CLOSING: begin
                // A reopen request wins over counter expiry.
                if (at_floor) begin
                    state_d  = OPENING;
                    tmr_load = 1'b1;
                    tmr_val  = OPEN_LOAD;
                    floor_d  = sensor_code;
                end else if (tmr_zero) begin
                    state_d = CLOSED;
                    floor_d = FLOOR_NONE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: begin
                state_d = CLOSED;
                floor_d = FLOOR_NONE;
            end
        endcase
    end

    // Output decode for the registered outputs
    always_comb begin
        door_d  = (state_d == OPEN);
        busy_d  = (state_d != CLOSED);
        fault_d = multi | (moving & (state != CLOSED));
    end

endmodule

// File: tb/tb_door_ctrl.sv
module tb_door_ctrl;

    localparam int OPEN_DELAY  = 2;
    localparam int HOLD_CYCLES = 4;
    localparam int CLOSE_DELAY = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       moving = 1'b0;
    logic       f1 = 1'b0, f2 = 1'b0, f3 = 1'b0;
    logic       door, busy, fault;
    logic [1:0] floor;

    door_ctrl #(
        .OPEN_DELAY  (OPEN_DELAY),
        .HOLD_CYCLES (HOLD_CYCLES),
        .CLOSE_DELAY (CLOSE_DELAY)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .moving (moving),
        .f1     (f1),
        .f2     (f2),
        .f3     (f3),
        .door   (door),
        .busy   (busy),
        .floor  (floor),
        .fault  (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       door;
        bit       busy;
        bit [1:0] floor;
        bit       fault;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_pushed = 0;
    int   n_popped = 0;

    // Reference model: door phase plus number of edges already spent in it.
    localparam int PH_SHUT = 0, PH_RISE = 1, PH_UP = 2, PH_FALL = 3;
    int       ph = PH_SHUT;
    int       spent = 0;
    bit [1:0] m_floor = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    endtask

    // Apply one cycle of inputs and predict the outputs after the next edge.
    task automatic step(input bit r, input bit m, input bit a, input bit b, input bit c);
        exp_t e;
        int   nsens;
        bit   here;
        int   code;
        @(negedge clk);
        rst = r; moving = m; f1 = a; f2 = b; f3 = c;
        nsens = int'(a) + int'(b) + int'(c);
        here  = !m && (nsens == 1);
        code  = a ? 1 : (b ? 2 : 3);
        if (r) begin
            ph = PH_SHUT; spent = 0; m_floor = 0;
            e.fault = 0;
        end else begin
            e.fault = (nsens > 1) || (m && ph != PH_SHUT);
            case (ph)
                PH_SHUT: if (here) begin ph = PH_RISE; spent = 0; m_floor = 2'(code); end
                PH_RISE: begin
                    if (!here) begin ph = PH_FALL; spent = 0; end
                    else if (spent + 1 >= OPEN_DELAY) begin ph = PH_UP; spent = 0; end
                    else spent++;
                end
                PH_UP: begin
                    if (m) begin ph = PH_FALL; spent = 0; end
                    else if (spent + 1 < HOLD_CYCLES) spent++;
                    else if (!here) begin ph = PH_FALL; spent = 0; end
                end
                default: begin
                    if (here) begin ph = PH_RISE; spent = 0; m_floor = 2'(code); end
                    else if (spent + 1 >= CLOSE_DELAY) begin ph = PH_SHUT; spent = 0; m_floor = 0; end
                    else spent++;
                end
            endcase
        end
        e.door  = (ph == PH_UP);
        e.busy  = (ph != PH_SHUT);
        e.floor = m_floor;
        exp_q.push_back(e);
        n_pushed++;
    endtask

    task automatic hold(input int n, input bit r, input bit m, input bit a, input bit b, input bit c);
        for (int i = 0; i < n; i++) step(r, m, a, b, c);
    endtask

    // Monitor: outputs are presented every cycle; compare just after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_popped++;
                check("door",  int'(door),  int'(e.door));
                check("busy",  int'(busy),  int'(e.busy));
                check("floor", int'(floor), int'(e.floor));
                check("fault", int'(fault), int'(e.fault));
            end
        end
    end

    initial begin
        int dur;
        bit rr, mm, aa, bb, cc;

        // Reset, then park at floor 2
        hold(2, 1, 0, 0, 0, 0);
        hold(8, 0, 0, 0, 1, 0);

        // Open at floor 1, sensor drops one cycle after door opens
        hold(1, 1, 0, 0, 0, 0);
        hold(OPEN_DELAY + 1, 0, 0, 1, 0, 0);
        hold(10, 0, 0, 0, 0, 0);

        // Open at floor 2, then car starts moving
        hold(1, 1, 0, 0, 0, 0);
        hold(OPEN_DELAY + 2, 0, 0, 0, 1, 0);
        hold(5, 0, 1, 0, 1, 0);
        hold(3, 0, 0, 0, 0, 0);

        // Reopen from CLOSING at floor 3
        hold(1, 1, 0, 0, 0, 0);
        hold(3, 0, 0, 0, 0, 1);
        hold(4, 0, 0, 0, 0, 0);
        hold(6, 0, 0, 0, 0, 1);

        // Reset while door is open
        hold(5, 0, 0, 1, 0, 0);
        hold(1, 1, 0, 1, 0, 0);
        hold(3, 0, 0, 0, 0, 0);

        // All sixteen {moving, f1, f2, f3} combinations
        for (int k = 0; k < 16; k++) begin
            hold(1, 1, 0, 0, 0, 0);
            hold(10, 0, k[3], k[2], k[1], k[0]);
        end

        // Randomized segments, biased toward a single sensor and a parked car
        for (int k = 0; k < 400; k++) begin
            dur = $urandom_range(1, 8);
            rr  = ($urandom_range(0, 40) == 0);
            mm  = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 5))
                0, 1, 2: begin
                    int s;
                    s = $urandom_range(1, 3);
                    aa = (s == 1); bb = (s == 2); cc = (s == 3);
                end
                3: begin aa = 0; bb = 0; cc = 0; end
                default: begin
                    aa = 1'($urandom); bb = 1'($urandom); cc = 1'($urandom);
                end
            endcase
            hold(dur, rr, mm, aa, bb, cc);
        end

        repeat (3) @(posedge clk);
        #2;
        check("drain", n_popped, n_pushed);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
